// File: rtl/alarm_pkg.sv
// Shared types and digit limits for the time-set controller.
// Holds the state encoding, per-digit maxima and small state decode helpers.
package alarm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EDIT_HT = 3'd1,
    EDIT_HU = 3'd2,
    EDIT_MT = 3'd3,
    EDIT_MU = 3'd4,
    COMMIT  = 3'd5
  } set_state_t;

  localparam logic [3:0] HR_T_MAX       = 4'd2;
  localparam logic [3:0] HR_U_MAX       = 4'd9;
  localparam logic [3:0] HR_U_MAX_AT_20 = 4'd3;
  localparam logic [3:0] MIN_T_MAX      = 4'd5;
  localparam logic [3:0] MIN_U_MAX      = 4'd9;

  function automatic logic is_edit(input set_state_t s);
    return (s == EDIT_HT) || (s == EDIT_HU) || (s == EDIT_MT) || (s == EDIT_MU);
  endfunction

  function automatic logic [1:0] state_sel(input set_state_t s);
    case (s)
      EDIT_HU: return 2'd1;
      EDIT_MT: return 2'd2;
      EDIT_MU: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/time_set_ctrl_digit_wrap.sv
// Combinational up/down step of one BCD digit with wrap at both ends.
// Up has priority when both requests are present.
module digit_wrap (
  input  logic [3:0] val,
  input  logic [3:0] max,
  input  logic       up,
  input  logic       down,
  output logic [3:0] next
);

  always_comb begin
    next = val;
    if (up) begin
      next = (val >= max) ? 4'd0 : val + 4'd1;
    end else if (down) begin
      next = (val == 4'd0) ? max : val - 4'd1;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven editor for HH:MM: edits a shadow copy one digit at a time and
// issues a one-cycle set strobe with all four digits on confirm.
module time_set_ctrl
  import alarm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int BLINK_HALF     = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       up_btn,
  input  logic       down_btn,
  input  logic       cancel_btn,
  input  logic [3:0] cur_hr_T,
  input  logic [3:0] cur_hr_U,
  input  logic [3:0] cur_min_T,
  input  logic [3:0] cur_min_U,
  output logic       set,
  output logic [3:0] hr_T_val,
  output logic [3:0] hr_U_val,
  output logic [3:0] min_T_val,
  output logic [3:0] min_U_val,
  output logic       editing,
  output logic [1:0] sel,
  output logic       blink
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

  set_state_t      state;
  set_state_t      state_d;
  logic [3:0]      sh_ht;
  logic [3:0]      sh_hu;
  logic [3:0]      sh_mt;
  logic [3:0]      sh_mu;
  logic [TO_W-1:0] to_cnt;
  logic [BL_W-1:0] bl_cnt;
  logic [3:0]      wrap_val;
  logic [3:0]      wrap_max;
  logic [3:0]      wrap_next;
  logic            capture;
  logic            apply_step;
  logic            any_btn;
  logic            blink_rst;

  // Entering the 20s hour range forces the units digit into 0..3.
  function automatic logic [3:0] clamp_hu(input logic [3:0] ht, input logic [3:0] hu);
    if ((ht == HR_T_MAX) && (hu > HR_U_MAX_AT_20)) begin
      return HR_U_MAX_AT_20;
    end
    return hu;
  endfunction

  assign hr_T_val  = sh_ht;
  assign hr_U_val  = sh_hu;
  assign min_T_val = sh_mt;
  assign min_U_val = sh_mu;
  assign any_btn   = mode_btn | up_btn | down_btn | cancel_btn;

  always_comb begin
    wrap_val = sh_ht;
    wrap_max = HR_T_MAX;
    case (state)
      EDIT_HU: begin
        wrap_val = sh_hu;
        wrap_max = (sh_ht == HR_T_MAX) ? HR_U_MAX_AT_20 : HR_U_MAX;
      end
      EDIT_MT: begin
        wrap_val = sh_mt;
        wrap_max = MIN_T_MAX;
      end
      EDIT_MU: begin
        wrap_val = sh_mu;
        wrap_max = MIN_U_MAX;
      end
      default: begin
        wrap_val = sh_ht;
        wrap_max = HR_T_MAX;
      end
    endcase
  end

  digit_wrap u_wrap (
    .val  (wrap_val),
    .max  (wrap_max),
    .up   (up_btn),
    .down (down_btn),
    .next (wrap_next)
  );

  // Next-state decode; one action per cycle with cancel > mode > up > down.
  always_comb begin
    state_d    = state;
    capture    = 1'b0;
    apply_step = 1'b0;
    case (state)
      IDLE: begin
        if (mode_btn) begin
          state_d = EDIT_HT;
          capture = 1'b1;
        end
      end
      COMMIT: state_d = IDLE;
      EDIT_HT, EDIT_HU, EDIT_MT, EDIT_MU: begin
        if (cancel_btn) begin
          state_d = IDLE;
        end else if (mode_btn) begin
          case (state)
            EDIT_HT: state_d = EDIT_HU;
            EDIT_HU: state_d = EDIT_MT;
            EDIT_MT: state_d = EDIT_MU;
            default: state_d = COMMIT;
          endcase
        end else if (up_btn || down_btn) begin
          apply_step = 1'b1;
        end else if (to_cnt == TO_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign blink_rst = !is_edit(state) || !is_edit(state_d) || mode_btn || up_btn || down_btn;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sh_ht   <= 4'd0;
      sh_hu   <= 4'd0;
      sh_mt   <= 4'd0;
      sh_mu   <= 4'd0;
      set     <= 1'b0;
      editing <= 1'b0;
      sel     <= 2'd0;
      blink   <= 1'b1;
      to_cnt  <= '0;
      bl_cnt  <= '0;
    end else begin
      state   <= state_d;
      set     <= (state_d == COMMIT);
      editing <= is_edit(state_d);
      sel     <= state_sel(state_d);

      if (capture) begin
        sh_ht <= cur_hr_T;
        sh_hu <= cur_hr_U;
        sh_mt <= cur_min_T;
        sh_mu <= cur_min_U;
      end else if (apply_step) begin
        case (state)
          EDIT_HT: begin
            sh_ht <= wrap_next;
            sh_hu <= clamp_hu(wrap_next, sh_hu);
          end
          EDIT_HU: sh_hu <= wrap_next;
          EDIT_MT: sh_mt <= wrap_next;
          EDIT_MU: sh_mu <= wrap_next;
          default: sh_ht <= sh_ht;
        endcase
      end

      if (is_edit(state) && is_edit(state_d) && !any_btn) begin
        to_cnt <= to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end

      if (blink_rst) begin
        blink  <= 1'b1;
        bl_cnt <= '0;
      end else if (bl_cnt == BL_LAST) begin
        blink  <= ~blink;
        bl_cnt <= '0;
      end else begin
        bl_cnt <= bl_cnt + BL_W'(1);
      end
    end
  end

endmodule
